// File: rtl/snn_pkg.sv
// Shared types and default sizing for the spiking-neuron timestep scheduler.
package snn_pkg;

  localparam int N_NEURONS_DEF   = 8;
  localparam int N_INPUTS_DEF    = 8;
  localparam int WEIGHT_SIZE_DEF = 8;
  localparam int V_MEM_SIZE_DEF  = 8;
  localparam int B_SIZE_DEF      = 8;
  localparam int CFG_DATA_W      = 8;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    INTEGRATE = 2'd1,
    DECAY     = 2'd2,
    DONE      = 2'd3
  } state_t;

  localparam logic FN_ACCUM = 1'b0;
  localparam logic FN_DECAY = 1'b1;

endpackage

// File: rtl/neuron_scheduler_datapath.sv
// Shared neuron arithmetic: wrapping accumulate (sel 0) or beta decay with
// strict threshold compare (sel 1). Results are the low V_MEM_SIZE bits.
module neuron_scheduler_datapath
  import snn_pkg::*;
#(
  parameter int WEIGHT_SIZE = WEIGHT_SIZE_DEF,
  parameter int V_MEM_SIZE  = V_MEM_SIZE_DEF,
  parameter int B_SIZE      = B_SIZE_DEF
) (
  input  logic                   function_sel,
  input  logic [V_MEM_SIZE-1:0]  v_mem,
  input  logic [WEIGHT_SIZE-1:0] weight,
  input  logic [B_SIZE-1:0]      beta,
  input  logic [V_MEM_SIZE-1:0]  v_th,
  output logic [V_MEM_SIZE-1:0]  result,
  output logic                   spike
);

  logic [V_MEM_SIZE-1:0] sum_lo;
  logic [V_MEM_SIZE-1:0] prod_lo;

  // Low bits of a sum/product depend only on the low bits of the operands,
  // so truncating before the operation yields the required modulo result.
  assign sum_lo  = v_mem + V_MEM_SIZE'(weight);
  assign prod_lo = v_mem * V_MEM_SIZE'(beta);

  always_comb begin
    result = sum_lo;
    spike  = 1'b0;
    if (function_sel == FN_DECAY) begin
      result = prod_lo;
      spike  = (prod_lo > v_th);
    end
  end

endmodule

// File: rtl/neuron_scheduler.sv
// Sequences one timestep over a layer: per-neuron weighted integration of
// latched input spikes, then decay, threshold and reset, through one datapath.
module neuron_scheduler
  import snn_pkg::*;
#(
  parameter int N_NEURONS   = N_NEURONS_DEF,
  parameter int N_INPUTS    = N_INPUTS_DEF,
  parameter int WEIGHT_SIZE = WEIGHT_SIZE_DEF,
  parameter int V_MEM_SIZE  = V_MEM_SIZE_DEF,
  parameter int B_SIZE      = B_SIZE_DEF
) (
  input  logic                                    wb_clk_i,
  input  logic                                    wb_rst_i,
  input  logic                                    cfg_we,
  input  logic [$clog2(N_NEURONS*N_INPUTS):0]     cfg_addr,
  input  logic [CFG_DATA_W-1:0]                   cfg_wdata,
  input  logic                                    clear_vmem,
  input  logic                                    start,
  input  logic [N_INPUTS-1:0]                     in_spikes,
  output logic                                    busy,
  output logic                                    done,
  output logic [N_NEURONS-1:0]                    out_spikes,
  output logic                                    cfg_err
);

  localparam int ADDR_W = $clog2(N_NEURONS*N_INPUTS) + 1;
  localparam int N_W    = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1;
  localparam int I_W    = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1;
  localparam logic [N_W-1:0] N_LAST = N_W'(N_NEURONS - 1);
  localparam logic [I_W-1:0] I_LAST = I_W'(N_INPUTS - 1);

  state_t                 state;
  logic [N_W-1:0]         n_idx;
  logic [I_W-1:0]         i_idx;
  logic [N_INPUTS-1:0]    spikes_lat;
  logic [V_MEM_SIZE-1:0]  v_mem  [N_NEURONS];
  logic [WEIGHT_SIZE-1:0] weight [N_NEURONS][N_INPUTS];
  logic [B_SIZE-1:0]      beta;
  logic [V_MEM_SIZE-1:0]  v_th;

  logic                   dp_sel;
  logic [V_MEM_SIZE-1:0]  dp_result;
  logic                   dp_spike;
  logic [ADDR_W-2:0]      cfg_idx;

  assign dp_sel  = (state == DECAY) ? FN_DECAY : FN_ACCUM;
  assign cfg_idx = cfg_addr[ADDR_W-2:0];

  neuron_scheduler_datapath #(
    .WEIGHT_SIZE (WEIGHT_SIZE),
    .V_MEM_SIZE  (V_MEM_SIZE),
    .B_SIZE      (B_SIZE)
  ) u_datapath (
    .function_sel (dp_sel),
    .v_mem        (v_mem[n_idx]),
    .weight       (weight[n_idx][i_idx]),
    .beta         (beta),
    .v_th         (v_th),
    .result       (dp_result),
    .spike        (dp_spike)
  );

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state      <= IDLE;
      n_idx      <= '0;
      i_idx      <= '0;
      spikes_lat <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      out_spikes <= '0;
      for (int k = 0; k < N_NEURONS; k++) v_mem[k] <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          // Clear lands on the same edge as start, so integration sees zeros.
          if (clear_vmem) begin
            for (int k = 0; k < N_NEURONS; k++) v_mem[k] <= '0;
          end
          if (start) begin
            spikes_lat <= in_spikes;
            n_idx      <= '0;
            i_idx      <= '0;
            busy       <= 1'b1;
            state      <= INTEGRATE;
          end
        end
        INTEGRATE: begin
          if (spikes_lat[i_idx]) v_mem[n_idx] <= dp_result;
          if (i_idx == I_LAST) state <= DECAY;
          else                 i_idx <= i_idx + 1'b1;
        end
        DECAY: begin
          v_mem[n_idx]      <= dp_spike ? '0 : dp_result;
          out_spikes[n_idx] <= dp_spike;
          i_idx             <= '0;
          if (n_idx == N_LAST) begin
            done  <= 1'b1;
            state <= DONE;
          end else begin
            n_idx <= n_idx + 1'b1;
            state <= INTEGRATE;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      beta    <= '0;
      v_th    <= '0;
      cfg_err <= 1'b0;
      for (int nn = 0; nn < N_NEURONS; nn++)
        for (int ii = 0; ii < N_INPUTS; ii++) weight[nn][ii] <= '0;
    end else begin
      cfg_err <= cfg_we && (state != IDLE);
      if (cfg_we && (state == IDLE)) begin
        if (cfg_addr[ADDR_W-1]) begin
          if (cfg_addr[0]) v_th <= V_MEM_SIZE'(cfg_wdata);
          else             beta <= B_SIZE'(cfg_wdata);
        end else begin
          for (int nn = 0; nn < N_NEURONS; nn++)
            for (int ii = 0; ii < N_INPUTS; ii++)
              if (cfg_idx == (ADDR_W-1)'(nn*N_INPUTS + ii))
                weight[nn][ii] <= WEIGHT_SIZE'(cfg_wdata);
        end
      end
    end
  end

endmodule
